// File: rtl/sid_voice_osc_pkg.sv
// Shared SID voice definitions: control-bit positions, noise seed, waveform-select codes.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package sid_voice_osc_pkg;

  // Bit positions inside the 8-bit voice control register
  localparam int CTRL_NOISE = 7;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_SYNC  = 1;

  // Noise shift register value after reset or while test is held
  localparam logic [22:0] LFSR_SEED = 23'h7FFFF8;

  // Waveform selection taken from control[7:4]
  typedef enum logic [3:0] {
    WAV_NONE  = 4'b0000,
    WAV_TRI   = 4'b0001,
    WAV_SAW   = 4'b0010,
    WAV_ST    = 4'b0011,
    WAV_PULSE = 4'b0100,
    WAV_PT    = 4'b0101,
    WAV_PS    = 4'b0110,
    WAV_PST   = 4'b0111,
    WAV_NOISE = 4'b1000
  } wave_sel_e;

  // Eight scattered LFSR bits form the top of the 12-bit noise sample
  function automatic logic [11:0] noise_tap(input logic [22:0] l);
    return {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0], 4'b0000};
  endfunction

endpackage

// File: rtl/sid_voice_osc_if.sv
// Voice oscillator signal bundle: control inputs, ROM lookup, waveform outputs.
// Latency: n/a (wires only).
// Backpressure: none; everything is paced by ce_1m.
interface sid_voice_osc_if;
  logic        ce_1m;
  logic [15:0] freq;
  logic [11:0] pw;
  logic [7:0]  control;
  logic        sync_in;
  logic        ring_msb;
  logic        msb_rising;
  logic        acc_msb;
  logic [11:0] tbl_addr;
  logic [7:0]  tbl_st;
  logic [7:0]  tbl_pt;
  logic [7:0]  tbl_ps;
  logic [7:0]  tbl_pst;
  logic [11:0] wave_out;
  logic [7:0]  osc3;

  // Driving side: register file, neighbour voices and the external ROMs
  modport master (
    output ce_1m, freq, pw, control, sync_in, ring_msb,
    output tbl_st, tbl_pt, tbl_ps, tbl_pst,
    input  msb_rising, acc_msb, tbl_addr, wave_out, osc3
  );

  // Oscillator side
  modport slave (
    input  ce_1m, freq, pw, control, sync_in, ring_msb,
    input  tbl_st, tbl_pt, tbl_ps, tbl_pst,
    output msb_rising, acc_msb, tbl_addr, wave_out, osc3
  );
endinterface

// File: rtl/sid_noise_lfsr.sv
// 23-bit noise LFSR with the 8-bit output tap, clocked by accumulator bit 19 rising.
// Latency: noise reflects a shift on the clock after the ce_1m that caused it.
// Backpressure: none; advances only when ce is asserted.
module sid_noise_lfsr
  import sid_voice_osc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        load,
  input  logic        step,
  output logic [11:0] noise
);

  logic [22:0] lfsr;

  // Seed on reset or test, otherwise shift with feedback bit22^bit17 when stepped
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (ce) begin
      if (load) begin
        lfsr <= LFSR_SEED;
      end else if (step) begin
        lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      end
    end
  end

  assign noise = noise_tap(lfsr);

endmodule

// File: rtl/sid_voice_osc.sv
// SID voice oscillator: 24-bit phase accumulator, noise/saw/tri/pulse and combined waveforms.
// Latency: acc/tbl_addr update on the ce_1m clock; wave_out two clocks after ce_1m.
// Backpressure: none; ce_1m pulses must be at least 3 clocks apart.
module sid_voice_osc
  import sid_voice_osc_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  sid_voice_osc_if.slave voice
);

  logic [23:0] acc;
  logic [23:0] acc_next;
  logic        msb_rising_q;
  logic [11:0] tbl_addr_q;
  logic [11:0] wave_q;
  logic [11:0] wave_next;
  logic [1:0]  ce_pipe;
  logic        test;
  logic        lfsr_step;
  logic        tri_flip;
  logic [11:0] noise;
  logic [11:0] saw;
  logic [11:0] tri_wave;
  logic [11:0] pulse;
  logic        unused_gate;

  assign test        = voice.control[CTRL_TEST];
  assign unused_gate = voice.control[0];

  // Next phase: test clears, hard sync clears, otherwise free-running add
  always_comb begin
    acc_next = acc + {8'd0, voice.freq};
    if (test) begin
      acc_next = '0;
    end else if (voice.control[CTRL_SYNC] && voice.sync_in) begin
      acc_next = '0;
    end
  end

  // Noise clock is a 0->1 transition of phase bit 19 across this update
  assign lfsr_step = ~acc[19] & acc_next[19];

  // Phase, msb edge flag and ROM index all move together on ce_1m
  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      msb_rising_q <= 1'b0;
      tbl_addr_q   <= '0;
    end else if (voice.ce_1m) begin
      acc          <= acc_next;
      msb_rising_q <= ~acc[23] & acc_next[23];
      tbl_addr_q   <= acc_next[23:12];
    end
  end

  sid_noise_lfsr u_noise (
    .clock (clock),
    .reset (reset),
    .ce    (voice.ce_1m),
    .load  (test),
    .step  (lfsr_step),
    .noise (noise)
  );

  // Two-stage delay gives the external ROMs one clock to answer tbl_addr
  always_ff @(posedge clock) begin
    if (reset) begin
      ce_pipe <= '0;
    end else begin
      ce_pipe <= {ce_pipe[0], voice.ce_1m};
    end
  end

  assign saw      = acc[23:12];
  assign tri_flip = acc[23] ^ (voice.control[CTRL_RING] & voice.ring_msb);
  assign tri_wave = {acc[22:12] ^ {11{tri_flip}}, 1'b0};
  assign pulse    = (test || (acc[23:12] >= voice.pw)) ? 12'hFFF : 12'h000;

  // Waveform mux; combined shapes come from the ROMs, pulse-gated where applicable
  always_comb begin
    wave_next = 12'h000;
    case (wave_sel_e'(voice.control[CTRL_NOISE:CTRL_TRI]))
      WAV_NONE:  wave_next = 12'h000;
      WAV_TRI:   wave_next = tri_wave;
      WAV_SAW:   wave_next = saw;
      WAV_PULSE: wave_next = pulse;
      WAV_NOISE: wave_next = noise;
      WAV_ST:    wave_next = {voice.tbl_st, 4'b0000};
      WAV_PT:    wave_next = {voice.tbl_pt, 4'b0000} & pulse;
      WAV_PS:    wave_next = {voice.tbl_ps, 4'b0000} & pulse;
      WAV_PST:   wave_next = {voice.tbl_pst, 4'b0000} & pulse;
      default:   wave_next = 12'h000;
    endcase
  end

  // Output sample register, loaded only at the end of the ROM pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      wave_q <= '0;
    end else if (ce_pipe[1]) begin
      wave_q <= wave_next;
    end
  end

  assign voice.msb_rising = msb_rising_q;
  assign voice.acc_msb    = acc[23];
  assign voice.tbl_addr   = tbl_addr_q;
  assign voice.wave_out   = wave_q;
  assign voice.osc3       = wave_q[11:4];

endmodule

// File: tb/tb_sid_voice_osc.sv
// Self-checking bench for sid_voice_osc: directed waveform scenarios plus random sweep.
// Latency: model tracks the two-clock wave pipeline by counting clocks since ce_1m.
// Backpressure: none; ce_1m driven with gaps of 3..6 clocks.
module tb_sid_voice_osc;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;

  sid_voice_osc_if vif();

  sid_voice_osc dut (
    .clock (clock),
    .reset (reset),
    .voice (vif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external ROM contents (arbitrary but distinct) ----------------
  function automatic int unsigned rom_st(input int unsigned a);
    return (a & 'hFF) ^ 'hA5;
  endfunction
  function automatic int unsigned rom_pt(input int unsigned a);
    return (((a & 'hF) << 4) | (a >> 8)) & 'hFF;
  endfunction
  function automatic int unsigned rom_ps(input int unsigned a);
    return (~(a >> 4)) & 'hFF;
  endfunction
  function automatic int unsigned rom_pst(input int unsigned a);
    return ((a >> 4) | ((a & 'hF) << 4)) & 'hFF;
  endfunction

  // Synchronous ROMs: data one clock after the address
  always @(posedge clock) begin
    vif.tbl_st  <= 8'(rom_st(32'(vif.tbl_addr)));
    vif.tbl_pt  <= 8'(rom_pt(32'(vif.tbl_addr)));
    vif.tbl_ps  <= 8'(rom_ps(32'(vif.tbl_addr)));
    vif.tbl_pst <= 8'(rom_pst(32'(vif.tbl_addr)));
  end

  // ---------------- behavioural model ----------------
  int unsigned m_acc = 0;
  int unsigned m_lfsr = 'h7FFFF8;
  int unsigned m_msbr = 0;
  int unsigned m_tbl = 0;
  int unsigned m_wave = 0;
  int unsigned m_nxt = 0;
  int          m_pend = 0;
  int          taps[8] = '{20, 18, 14, 11, 9, 5, 2, 0};

  function automatic int unsigned bitof(input int unsigned v, input int n);
    return (v >> n) & 1;
  endfunction

  function automatic int unsigned model_wave();
    int unsigned saw = m_acc >> 12;
    int unsigned ctl = 32'(vif.control);
    int unsigned low = saw % 2048;
    int unsigned flip = bitof(m_acc, 23) ^ (bitof(ctl, 2) & 32'(vif.ring_msb));
    int unsigned triw = (flip != 0) ? 2 * (2047 - low) : 2 * low;
    int unsigned pul = (bitof(ctl, 3) != 0 || saw >= 32'(vif.pw)) ? 'hFFF : 0;
    int unsigned noi = 0;
    for (int i = 0; i < 8; i++) noi = noi * 2 + bitof(m_lfsr, taps[i]);
    noi = noi * 16;
    case (ctl >> 4)
      0: return 0;
      1: return triw;
      2: return saw;
      3: return rom_st(saw) * 16;
      4: return pul;
      5: return (rom_pt(saw) * 16) & pul;
      6: return (rom_ps(saw) * 16) & pul;
      7: return (rom_pst(saw) * 16) & pul;
      8: return noi;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_acc = 0; m_lfsr = 'h7FFFF8; m_msbr = 0; m_tbl = 0; m_wave = 0; m_pend = 0;
    end else begin
      if (m_pend == 1) m_wave = model_wave();
      if (m_pend > 0) m_pend--;
      if (vif.ce_1m) begin
        if (vif.control[3]) m_nxt = 0;
        else if (vif.control[1] && vif.sync_in) m_nxt = 0;
        else m_nxt = (m_acc + 32'(vif.freq)) % 'h1000000;
        if (vif.control[3]) m_lfsr = 'h7FFFF8;
        else if (bitof(m_acc, 19) == 0 && bitof(m_nxt, 19) == 1)
          m_lfsr = (m_lfsr * 2 + (bitof(m_lfsr, 22) ^ bitof(m_lfsr, 17))) % 'h800000;
        m_msbr = (m_acc < 'h800000 && m_nxt >= 'h800000) ? 1 : 0;
        m_acc = m_nxt;
        m_tbl = m_nxt >> 12;
        m_pend = 2;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("msb_rising", 32'(vif.msb_rising), m_msbr);
      check("acc_msb", 32'(vif.acc_msb), m_acc >> 23);
      check("tbl_addr", 32'(vif.tbl_addr), m_tbl);
      check("wave_out", 32'(vif.wave_out), m_wave);
      check("osc3", 32'(vif.osc3), m_wave >> 4);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int gap);
    vif.ce_1m = 1'b1;
    @(posedge clock); #1;
    vif.ce_1m = 1'b0;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time budget");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  logic [7:0] codes[12] = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h80, 8'h30,
                            8'h50, 8'h60, 8'h70, 8'h90, 8'hF0, 8'hC0};

  initial begin
    int rises;
    logic [7:0] ctl;
    vif.ce_1m = 1'b0; vif.freq = '0; vif.pw = '0; vif.control = '0;
    vif.sync_in = 1'b0; vif.ring_msb = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_wave", 32'(vif.wave_out), 0);
    check("rst_tbl", 32'(vif.tbl_addr), 0);
    check("rst_msbr", 32'(vif.msb_rising), 0);
    check("rst_accmsb", 32'(vif.acc_msb), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Sawtooth ramp over a full period
    vif.freq = 16'h1000; vif.control = 8'h20;
    rises = 0;
    for (int k = 1; k <= 4096; k++) begin
      pulse(2);
      if (vif.msb_rising) rises++;
      if (k == 1)    check("saw_first", 32'(vif.wave_out), 'h001);
      if (k == 2048) check("saw_msb_rise", 32'(vif.msb_rising), 1);
      if (k == 4095) check("saw_top", 32'(vif.wave_out), 'hFFF);
      if (k == 4096) check("saw_wrap", 32'(vif.wave_out), 'h000);
    end
    check("saw_rise_count", 32'(rises), 1);

    // Pulse threshold then test override
    do_reset();
    vif.control = 8'h40; vif.pw = 12'h800; vif.freq = 16'h1000;
    for (int k = 1; k <= 2048; k++) begin
      pulse(2);
      if (k == 'h7FF) check("pulse_below", 32'(vif.wave_out), 'h000);
      if (k == 'h800) check("pulse_at_pw", 32'(vif.wave_out), 'hFFF);
    end
    vif.control = 8'h48;
    pulse(2);
    check("test_pulse", 32'(vif.wave_out), 'hFFF);
    check("test_tbl", 32'(vif.tbl_addr), 0);
    pulse(3);
    check("test_pulse_held", 32'(vif.wave_out), 'hFFF);
    check("test_model_lfsr", m_lfsr, 'h7FFFF8);

    // Ring modulation on triangle at zero phase
    do_reset();
    vif.freq = 16'h0000; vif.control = 8'h14; vif.ring_msb = 1'b1;
    pulse(2);
    check("ring_on", 32'(vif.wave_out), 'hFFE);
    vif.ring_msb = 1'b0;
    pulse(2);
    check("ring_off", 32'(vif.wave_out), 'h000);

    // Hard sync from phase 0x123456
    do_reset();
    vif.control = 8'h22; vif.freq = 16'h1234;
    repeat (256) pulse(2);
    vif.freq = 16'h0056;
    pulse(2);
    check("sync_pre_tbl", 32'(vif.tbl_addr), 'h123);
    check("sync_pre_saw", 32'(vif.wave_out), 'h123);
    vif.sync_in = 1'b1;
    pulse(2);
    vif.sync_in = 1'b0;
    check("sync_tbl", 32'(vif.tbl_addr), 0);
    check("sync_wave", 32'(vif.wave_out), 'h000);

    // Combined pulse+saw+tri via ROM
    do_reset();
    vif.control = 8'h70; vif.pw = 12'h000; vif.freq = 16'hFFFF;
    repeat (256) pulse(2);
    check("comb_tbl", 32'(vif.tbl_addr), 'hFFF);
    check("comb_pst", 32'(vif.wave_out), 'hFF0);
    vif.pw = 12'hFFF; vif.freq = 16'h1000;
    pulse(2);
    check("comb_pw_max", 32'(vif.wave_out), 'h000);

    // Noise from seed, then reset mid-pipeline
    do_reset();
    vif.control = 8'h80; vif.freq = 16'h0800;
    for (int k = 1; k <= 1280; k++) begin
      pulse(2);
      if (k == 255)  check("noise_model_pre", m_lfsr, 'h7FFFF8);
      if (k == 256)  check("noise_model_first", m_lfsr, 'h7FFFF0);
      if (k == 256)  check("noise_seed_wave", 32'(vif.wave_out), 'hFC0);
      if (k == 1279) check("noise_two_shifts", 32'(vif.wave_out), 'hFC0);
      if (k == 1280) check("noise_three_shifts", 32'(vif.wave_out), 'hF80);
    end
    vif.ce_1m = 1'b1;
    @(posedge clock); #1;
    vif.ce_1m = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_wave", 32'(vif.wave_out), 0);
    check("midrst_osc3", 32'(vif.osc3), 0);
    check("midrst_tbl", 32'(vif.tbl_addr), 0);
    check("midrst_accmsb", 32'(vif.acc_msb), 0);
    check("midrst_msbr", 32'(vif.msb_rising), 0);
    repeat (2) @(posedge clock);
    #1;
    check("midrst_discard", 32'(vif.wave_out), 0);

    // Randomised sweep against the model
    for (int k = 0; k < 2000; k++) begin
      if (k % 500 == 0) do_reset();
      ctl = codes[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) ctl[3] = 1'b1;
      ctl[2] = 1'($urandom);
      ctl[1] = 1'($urandom);
      ctl[0] = 1'($urandom);
      vif.control  = ctl;
      vif.freq     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      vif.pw       = 12'($urandom);
      vif.sync_in  = ($urandom_range(0, 7) == 0);
      vif.ring_msb = 1'($urandom);
      pulse($urandom_range(2, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sid_voice_osc.md
SID_VOICE_OSC -- requirements
Module: sid_voice_osc

Interface
REQ-001 Parameters: none.
REQ-002 clock  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ce_1m  in  1  SID-cycle enable, one clock wide; at least 3 clocks between pulses.
REQ-005 freq  in  16  oscillator frequency word.
REQ-006 pw  in  12  pulse width.
REQ-007 control  in  8  bit7 noise, bit6 pulse, bit5 saw, bit4 tri, bit3 test, bit2 ring, bit1 sync, bit0 gate (unused here).
REQ-008 sync_in  in  1  msb_rising of the sync-source voice.
REQ-009 ring_msb  in  1  acc_msb of the ring-source voice.
REQ-010 msb_rising  out  1  accumulator bit 23 went 0->1 on the last update.
REQ-011 acc_msb  out  1  accumulator bit 23.
REQ-012 tbl_addr  out  12  registered index to the combined-waveform ROMs.
REQ-013 tbl_st, tbl_pt, tbl_ps, tbl_pst  in  8 each  ROM data; valid one clock after tbl_addr.
REQ-014 wave_out  out  12  selected waveform.
REQ-015 osc3  out  8  wave_out[11:4].

Function
REQ-016 24-bit accumulator acc updates only on ce_1m; priority: test=1 -> 0; else sync=1 and sync_in=1 -> 0; else acc+freq, modulo 2^24.
REQ-017 msb_rising registered on ce_1m = (old acc[23]=0 and new acc[23]=1), held until the next ce_1m.
REQ-018 23-bit noise LFSR: on ce_1m with test=1 load 0x7FFFF8; else, if acc[19] goes 0->1 on that update, shift left with bit0 = bit22 XOR bit17.
REQ-019 Noise value = {lfsr[20],lfsr[18],lfsr[14],lfsr[11],lfsr[9],lfsr[5],lfsr[2],lfsr[0], 4'b0}.
REQ-020 Saw = acc[23:12].
REQ-021 Triangle: m = acc[23] XOR (ring AND ring_msb); tri = {acc[22:12] XOR {11{m}}, 1'b0}.
REQ-022 Pulse = 0xFFF when test=1 or acc[23:12] >= pw, else 0x000; unsigned compare.
REQ-023 tbl_addr loads acc[23:12] (post-update value) on the same clock as the acc update.
REQ-024 wave_out registers on the second clock after ce_1m. Select on control[7:4]:
- 0000 -> 0
- 0001 -> tri
- 0010 -> saw
- 0100 -> pulse
- 1000 -> noise
- 0011 -> {tbl_st,4'b0}
- 0101 -> {tbl_pt,4'b0} AND pulse
- 0110 -> {tbl_ps,4'b0} AND pulse
- 0111 -> {tbl_pst,4'b0} AND pulse
- any other code with bit7 set -> 0
REQ-025 Between ce_1m pulses, acc, lfsr, msb_rising and tbl_addr hold; wave_out changes only on the clock of REQ-024.
REQ-026 Control, freq and pw changes take effect at the next ce_1m (acc/lfsr) or the next wave_out update (selection).
REQ-027 test=1 held: acc stays 0, lfsr stays 0x7FFFF8, msb_rising=0, pulse = 0xFFF.

Reset
REQ-028 reset=1 at a clock edge overrides ce_1m.
REQ-029 Reset values: acc=0, lfsr=0x7FFFF8, msb_rising=0, acc_msb=0, tbl_addr=0, wave_out=0, osc3=0.
REQ-030 Reset asserted mid-pipeline discards any pending wave_out update.

Structure
REQ-031 Shared sid package holds control-bit index constants, the LFSR seed 0x7FFFF8 and the waveform-select codes.
REQ-032 One sub-module, sid_noise_lfsr (LFSR plus REQ-019 bit tap), is natural.
REQ-033 Combined-waveform ROMs are external, with one tbl_addr fanning out to all four.

Verification
REQ-034 freq=0x1000, control=0x20, 4096 ce_1m pulses -> wave_out steps 0x001..0xFFF then wraps to 0x000; msb_rising pulses once per 4096 ce_1m (acc 0x7FF000->0x800000).
REQ-035 control=0x40, pw=0x800, freq=0x1000 -> wave_out 0x000 for saw 0x000..0x7FF, 0xFFF from saw 0x800; control=0x48 -> 0xFFF constantly.
REQ-036 Ring: control=0x14, ring_msb=1, acc=0x000000 -> wave_out 0xFFE; with ring_msb=0 -> 0x000.
REQ-037 Sync: control=0x22, sync_in=1 at ce_1m with acc=0x123456 -> acc=0, tbl_addr=0, wave_out=0x000 two clocks later.
REQ-038 Combined: control=0x70, pw=0, tbl_pst returns 0xFF for tbl_addr=0xFFF -> wave_out=0xFF0; with pw=0xFFF and acc[23:12]<0xFFF -> 0x000.
REQ-039 Noise: reset then freq=0x0800, control=0x80 -> first LFSR shift after 256 ce_1m (acc 0x07F800->0x080000); reset asserted mid-run -> all REQ-029 values on the next clock.
